// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg
// Handshaked pipeline-stage register placed between MIPS pipeline stages.
// It carries a payload plus exception and delay-slot sideband from the
// upstream stage to the downstream stage. Flow control is valid/ready.
//
// Build option: PIPE_SKID_EN
//   defined   - two-entry skid buffer (main + skid slot) with a registered
//               in_ready, so out_ready has no combinational path to in_ready.
//   undefined - single entry; in_ready = !out_valid || out_ready.
//
// Ports
//   clock, resetn            clock; asynchronous active-low reset
//   in_valid/in_ready        upstream handshake
//   in_data, in_exc_*        payload and exception sideband
//   in_delayslot             entry is a delay-slot instruction
//   next_delayslot           sampled into cur_delayslot on accept
//   out_valid/out_ready      downstream handshake
//   out_data, out_exc_*,     presented entry; all zero while out_valid=0
//   out_delayslot
//   cur_delayslot            next_delayslot of the last accepted entry
//   flush                    drop every held entry and any same-cycle input
//   cnt_clr                  synchronous clear of stall_cnt
//   stall_cnt                saturating count of out_valid && !out_ready
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int EXC_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_exc_valid,
    input  logic [EXC_W-1:0]  in_exc_code,
    input  logic [31:0]       in_exc_addr,
    input  logic              in_delayslot,
    input  logic              next_delayslot,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_exc_valid,
    output logic [EXC_W-1:0]  out_exc_code,
    output logic [31:0]       out_exc_addr,
    output logic              out_delayslot,
    output logic              cur_delayslot,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              exc_valid;
        logic [EXC_W-1:0]  exc_code;
        logic [31:0]       exc_addr;
        logic              delayslot;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q, state_d;
    entry_t in_entry, main_q;
    logic   accept, release_x, main_ld;

    assign in_entry = '{data:      in_data,
                        exc_valid: in_exc_valid,
                        exc_code:  in_exc_code,
                        exc_addr:  in_exc_addr,
                        delayslot: in_delayslot};

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready && !flush;
    assign release_x = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    entry_t skid_q;
    logic   skid_ld, main_from_skid, in_ready_q;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                main_ld = 1'b1;
            end
            ONE: begin
                if (accept && release_x) begin
                    main_ld = 1'b1;
                end else if (accept) begin
                    // Downstream stalled: park the newcomer behind main.
                    state_d = FULL;
                    skid_ld = 1'b1;
                end else if (release_x) begin
                    state_d = EMPTY;
                end
            end
            FULL: if (release_x) begin
                state_d        = ONE;
                main_from_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Registered ready: computed from the next state so it is correct the
    // cycle the state changes, without looking at out_ready combinationally.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) in_ready_q <= 1'b1;
        else         in_ready_q <= (state_d != FULL);
    end
    assign in_ready = in_ready_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)      skid_q <= '0;
        else if (skid_ld) skid_q <= in_entry;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)             main_q <= '0;
        else if (main_ld)        main_q <= in_entry;
        else if (main_from_skid) main_q <= skid_q;
    end
`else
    always_comb begin
        state_d = state_q;
        main_ld = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d = ONE;
                main_ld = 1'b1;
            end
            ONE: begin
                // Accept with a simultaneous release overwrites in place.
                if (accept)         main_ld = 1'b1;
                else if (release_x) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)      main_q <= '0;
        else if (main_ld) main_q <= in_entry;
    end
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    // Bubbles present all-zero payload and sideband downstream.
    assign out_data      = out_valid ? main_q.data      : '0;
    assign out_exc_valid = out_valid ? main_q.exc_valid : 1'b0;
    assign out_exc_code  = out_valid ? main_q.exc_code  : '0;
    assign out_exc_addr  = out_valid ? main_q.exc_addr  : '0;
    assign out_delayslot = out_valid ? main_q.delayslot : 1'b0;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)     cur_delayslot <= 1'b0;
        else if (flush)  cur_delayslot <= 1'b0;
        else if (accept) cur_delayslot <= next_delayslot;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)
            stall_cnt <= '0;
        else if (cnt_clr)
            stall_cnt <= '0;
        else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised, handshaked pipeline-stage register; next generation of the fixed-width stage registers between the decode, execute and memory stages of the MIPS core. It carries a DATA_W payload plus exception and delay-slot sideband from an upstream stage to a downstream stage using valid/ready flow control in place of a global stall vector. It supports flush and optional skid buffering, and it counts back-pressure cycles for performance analysis.

## Interface
- DATA_W, 160: payload width (packed addr/inst/regs/imm).
- EXC_W, 6: exception code width.
- CNT_W, 16: stall counter width.

- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream entry present.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  payload.
- in_exc_valid / in_exc_code / in_exc_addr  in  1 / EXC_W / 32  exception sideband.
- in_delayslot  in  1  entry is a delay-slot instruction.
- next_delayslot  in  1  next entry will be a delay slot.
- out_valid  out  1  entry presented downstream.
- out_ready  in  1  downstream accepts.
- out_data / out_exc_valid / out_exc_code / out_exc_addr / out_delayslot  out  matching widths.
- cur_delayslot  out  1  registered next_delayslot of last accepted entry.
- flush  in  1  discard all held entries.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating back-pressure cycle count.

## Operation
- Accept = in_valid && in_ready && !flush. Release = out_valid && out_ready.
- On accept: capture in_data, all sideband fields and in_delayslot into the entry. Load next_delayslot into cur_delayslot. cur_delayslot holds on all other cycles.
- Bubble rule: when out_valid=0, out_data, out_exc_valid, out_exc_code, out_exc_addr and out_delayslot are forced to 0.
- Entry states with PIPE_SKID_EN defined:
  - EMPTY -> ONE on accept.
  - ONE -> EMPTY on release without accept; stays ONE on release with accept.
  - ONE -> FULL on accept without release; the new entry goes to the skid slot.
  - FULL -> ONE on release; the skid entry moves to main. No accept is possible in FULL.
  - Output is always driven from the main slot.
- Flush: from any state go to EMPTY next cycle and clear cur_delayslot. An in_valid presented in the same cycle is dropped. A same-cycle release still counts as delivered.
- stall_cnt: +1 each cycle with out_valid && !out_ready. Saturates at all ones. cnt_clr has priority over increment.

## Timing
- Reset (resetn=0, asynchronous) forces:
  - out_valid=0, all out_* payload and sideband = 0;
  - cur_delayslot=0, stall_cnt=0, state EMPTY;
  - in_ready=1.
- Latency: accept in cycle N -> out_valid=1 in cycle N+1.
- Throughput: 1 entry per cycle while out_ready=1.
- With PIPE_SKID_EN: in_ready is a flop, equal to (state != FULL). It has no combinational path from out_ready.
- Order is strictly FIFO. No entry is duplicated or lost except by flush.
- Reset deasserted mid-transfer: the entry is lost, and the first accept is possible in the cycle after resetn rises.

## Configuration
- PIPE_SKID_EN defined: two-entry skid buffer as described above; in_ready is registered, breaking the ready timing path.
- PIPE_SKID_EN undefined: single entry with no FULL state.
  - in_ready = !out_valid || out_ready (combinational).
  - Accept with simultaneous release replaces the entry in place.
  - All other behaviour is identical.

## Test plan
- Reset: hold resetn=0 with in_valid=1 and in_data=0xA5.. -> out_valid=0, outputs 0, in_ready=1, stall_cnt=0.
- Stream: 8 back-to-back entries with data 1..8 and out_ready=1 -> out_data 1..8 appear in cycles N+1..N+8 with no gaps; stall_cnt=0.
- Back-pressure (skid build): send entries 1, 2, 3 with out_ready=0 -> entry 1 held, in_ready=0 after entry 2, entry 3 not accepted. Raise out_ready -> outputs 1, 2, 3 in order; stall_cnt counts the held cycles exactly.
- Flush in FULL with in_valid=1 (data 0x55) -> next cycle out_valid=0, outputs 0, cur_delayslot=0; 0x55 never appears.
- Delay slot: accept with next_delayslot=1, then stall 3 cycles with next_delayslot toggling -> cur_delayslot stays 1 until the next accept.
- Saturation: CNT_W=4, hold out_valid && !out_ready for 20 cycles -> stall_cnt=15. Pulse cnt_clr during an active stall -> stall_cnt=0 next cycle.
